// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
// Captures writeback-stage commit records into a small circular buffer.
// A trace or debug consumer reads them back in commit order over a
// valid/ready port. Normal records that arrive while the buffer holds
// DEPTH-1 entries are dropped and counted. The last slot is kept free for
// the halting (stop) record, so the halt record is always delivered. After
// the halt record is accepted by the consumer, the block reports
// completion and stays idle until reset.
module commit_trace_fifo #(
    parameter int DEPTH      = 8,
    parameter int PC_WD      = 32,
    parameter int INST_WD    = 32,
    parameter int RF_DATA_WD = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ws_valid,
    input  logic [PC_WD-1:0]      ws_pc,
    input  logic [INST_WD-1:0]    ws_inst,
    input  logic                  ws_exp,
    input  logic                  ws_mret,
    input  logic                  ws_rf_wen,
    input  logic [4:0]            ws_rf_wnum,
    input  logic [RF_DATA_WD-1:0] ws_rf_wdata,
    input  logic                  stop,
    output logic                  tr_valid,
    input  logic                  tr_ready,
    output logic [PC_WD-1:0]      tr_pc,
    output logic [INST_WD-1:0]    tr_inst,
    output logic                  tr_exp,
    output logic                  tr_mret,
    output logic                  tr_rf_wen,
    output logic [4:0]            tr_rf_wnum,
    output logic [RF_DATA_WD-1:0] tr_rf_wdata,
    output logic [31:0]           tr_seq,
    output logic                  tr_halt,
    output logic                  full,
    output logic [15:0]           drop_cnt,
    output logic                  halted
);

    localparam int PTR_WD = $clog2(DEPTH);
    localparam int CNT_WD = PTR_WD + 1;
    // Normal records may fill up to DEPTH-1 entries; the halt record may use the last slot.
    localparam logic [CNT_WD-1:0] CNT_NORM_LIM = CNT_WD'(DEPTH - 1);
    localparam logic [CNT_WD-1:0] CNT_HALT_LIM = CNT_WD'(DEPTH);

    typedef struct packed {
        logic [PC_WD-1:0]      pc;
        logic [INST_WD-1:0]    inst;
        logic                  exp;
        logic                  mret;
        logic                  rf_wen;
        logic [4:0]            rf_wnum;
        logic [RF_DATA_WD-1:0] rf_wdata;
        logic [31:0]           seq;
        logic                  halt;
    } rec_t;

    localparam int REC_WD = $bits(rec_t);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    rec_t              mem_r [DEPTH];
    logic [PTR_WD-1:0] wr_ptr_r;
    logic [PTR_WD-1:0] rd_ptr_r;
    logic [CNT_WD-1:0] count_r;
    logic [31:0]       seq_r;
    logic [15:0]       drop_cnt_r;
    logic              halted_r;
    state_t            state_r;
    state_t            state_nxt_s;

    rec_t              head_s;
    rec_t              wr_rec_s;
    logic              tr_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic              seq_inc_s;

    assign head_s     = mem_r[rd_ptr_r];
    assign tr_valid_s = (count_r != {CNT_WD{1'b0}}) && (state_r != ST_DONE);
    assign pop_s      = tr_valid_s & tr_ready;

    // Assemble the record to store from the current commit, tagged with the pre-increment sequence number.
    always_comb begin
        wr_rec_s          = {REC_WD{1'b0}};
        wr_rec_s.pc       = ws_pc;
        wr_rec_s.inst     = ws_inst;
        wr_rec_s.exp      = ws_exp;
        wr_rec_s.mret     = ws_mret;
        wr_rec_s.rf_wen   = ws_rf_wen;
        wr_rec_s.rf_wnum  = ws_rf_wnum;
        wr_rec_s.rf_wdata = ws_rf_wdata;
        wr_rec_s.seq      = seq_r;
        wr_rec_s.halt     = stop;
    end

    // Next-state and push/drop decisions; admission uses occupancy before the edge.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        drop_s      = 1'b0;
        seq_inc_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (ws_valid) begin
                    seq_inc_s = 1'b1;
                    if (stop) begin
                        push_s      = (count_r < CNT_HALT_LIM);
                        state_nxt_s = ST_DRAIN;
                    end else if (count_r < CNT_NORM_LIM) begin
                        push_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    seq_inc_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_s.halt) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State register and completion flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_DRAIN) && (state_nxt_s == ST_DONE)) begin
                halted_r <= 1'b1;
            end
        end
    end

    // Record storage; cleared on reset so the data outputs read zero afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {REC_WD{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= wr_rec_s;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {PTR_WD{1'b0}};
            rd_ptr_r <= {PTR_WD{1'b0}};
            count_r  <= {CNT_WD{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WD'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WD'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_WD'(1);
                2'b01:   count_r <= count_r - CNT_WD'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Commit sequence number and saturating drop counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seq_r      <= 32'd0;
            drop_cnt_r <= 16'd0;
        end else begin
            if (seq_inc_s) begin
                seq_r <= seq_r + 32'd1;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
        end
    end

    assign tr_valid    = tr_valid_s;
    assign tr_pc       = head_s.pc;
    assign tr_inst     = head_s.inst;
    assign tr_exp      = head_s.exp;
    assign tr_mret     = head_s.mret;
    assign tr_rf_wen   = head_s.rf_wen;
    assign tr_rf_wnum  = head_s.rf_wnum;
    assign tr_rf_wdata = head_s.rf_wdata;
    assign tr_seq      = head_s.seq;
    assign tr_halt     = tr_valid_s & head_s.halt;
    assign full        = (count_r >= CNT_NORM_LIM);
    assign drop_cnt    = drop_cnt_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: a queue-based reference model checked
// against the DUT on every falling edge, plus directed scenarios with
// hand-computed literal expectations.
module tb_commit_trace_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_inst;
    logic        ws_exp;
    logic        ws_mret;
    logic        ws_rf_wen;
    logic [4:0]  ws_rf_wnum;
    logic [63:0] ws_rf_wdata;
    logic        stop;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_pc;
    logic [31:0] tr_inst;
    logic        tr_exp;
    logic        tr_mret;
    logic        tr_rf_wen;
    logic [4:0]  tr_rf_wnum;
    logic [63:0] tr_rf_wdata;
    logic [31:0] tr_seq;
    logic        tr_halt;
    logic        full;
    logic [15:0] drop_cnt;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_fifo #(.DEPTH(DEPTH), .PC_WD(32), .INST_WD(32), .RF_DATA_WD(64)) dut (
        .clk(clk), .resetn(resetn),
        .ws_valid(ws_valid), .ws_pc(ws_pc), .ws_inst(ws_inst), .ws_exp(ws_exp),
        .ws_mret(ws_mret), .ws_rf_wen(ws_rf_wen), .ws_rf_wnum(ws_rf_wnum),
        .ws_rf_wdata(ws_rf_wdata), .stop(stop),
        .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_inst(tr_inst),
        .tr_exp(tr_exp), .tr_mret(tr_mret), .tr_rf_wen(tr_rf_wen),
        .tr_rf_wnum(tr_rf_wnum), .tr_rf_wdata(tr_rf_wdata), .tr_seq(tr_seq),
        .tr_halt(tr_halt), .full(full), .drop_cnt(drop_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exp;
        logic        mret;
        logic        wen;
        logic [4:0]  wnum;
        logic [63:0] wdata;
        logic [31:0] seq;
        logic        halt;
    } rec_t;

    // Reference model: mode 0 = accepting commits, 1 = draining after halt, 2 = complete.
    rec_t        m_q[$];
    logic [31:0] m_seq;
    logic [15:0] m_drop;
    int          m_mode;
    logic        m_halted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: admission judged on occupancy before the edge.
    always @(posedge clk or negedge resetn) begin : model
        int   sz;
        bit   do_pop;
        bit   do_push;
        rec_t r;
        rec_t h;
        if (!resetn) begin
            m_q.delete();
            m_seq    = 32'd0;
            m_drop   = 16'd0;
            m_mode   = 0;
            m_halted = 1'b0;
        end else begin
            sz      = m_q.size();
            do_pop  = (sz != 0) && (m_mode != 2) && (tr_ready === 1'b1);
            do_push = 1'b0;
            r = '{pc: ws_pc, inst: ws_inst, exp: ws_exp, mret: ws_mret, wen: ws_rf_wen,
                  wnum: ws_rf_wnum, wdata: ws_rf_wdata, seq: m_seq, halt: stop};
            if (m_mode == 0 && ws_valid) begin
                if (stop) begin
                    do_push = (sz < DEPTH);
                    m_mode  = 1;
                end else if (sz < DEPTH - 1) begin
                    do_push = 1'b1;
                end else if (m_drop != 16'hFFFF) begin
                    m_drop = m_drop + 16'd1;
                end
                m_seq = m_seq + 32'd1;
            end
            if (do_pop) begin
                h = m_q.pop_front();
                if (h.halt) begin
                    m_mode   = 2;
                    m_halted = 1'b1;
                end
            end
            if (do_push) m_q.push_back(r);
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin : compare
        logic exp_v;
        exp_v = (m_q.size() != 0) && (m_mode != 2);
        chk("tr_valid", 64'(tr_valid), 64'(exp_v));
        chk("full", 64'(full), 64'(m_q.size() >= DEPTH - 1));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("halted", 64'(halted), 64'(m_halted));
        if (exp_v) begin
            chk("tr_pc", 64'(tr_pc), 64'(m_q[0].pc));
            chk("tr_inst", 64'(tr_inst), 64'(m_q[0].inst));
            chk("tr_exp", 64'(tr_exp), 64'(m_q[0].exp));
            chk("tr_mret", 64'(tr_mret), 64'(m_q[0].mret));
            chk("tr_rf_wen", 64'(tr_rf_wen), 64'(m_q[0].wen));
            chk("tr_rf_wnum", 64'(tr_rf_wnum), 64'(m_q[0].wnum));
            chk("tr_rf_wdata", tr_rf_wdata, m_q[0].wdata);
            chk("tr_seq", 64'(tr_seq), 64'(m_q[0].seq));
            chk("tr_halt", 64'(tr_halt), 64'(m_q[0].halt));
        end else begin
            chk("tr_halt_idle", 64'(tr_halt), 64'd0);
        end
    end

    task automatic drive(input logic v, input logic s, input logic [31:0] pc);
        logic [31:0] p;
        p           = pc;
        ws_valid    = v;
        stop        = s;
        ws_pc       = p;
        ws_inst     = ~p;
        ws_exp      = p[2];
        ws_mret     = p[3];
        ws_rf_wen   = p[4];
        ws_rf_wnum  = p[6:2];
        ws_rf_wdata = {p, ~p};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        tr_ready = 1'b0;
        drive(1'b0, 1'b0, 32'd0);
        step();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        tr_ready = 1'b0;
        drive(1'b0, 1'b0, 32'd0);
        step();
        chk("rst_tr_valid", 64'(tr_valid), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_tr_pc", 64'(tr_pc), 64'd0);
        chk("rst_tr_seq", 64'(tr_seq), 64'd0);
        step();
        resetn = 1'b1;

        // Scenario 1: three commits streamed straight through.
        tr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h8000_0000 + 32'(4 * i));
            step();
            chk("s1_valid", 64'(tr_valid), 64'd1);
            chk("s1_seq", 64'(tr_seq), 64'(i));
            chk("s1_pc", 64'(tr_pc), 64'h8000_0000 + 64'(4 * i));
        end
        drive(1'b0, 1'b0, 32'd0);
        step();
        chk("s1_empty", 64'(tr_valid), 64'd0);
        chk("s1_drop", 64'(drop_cnt), 64'd0);

        // Scenario 2: ten commits with a stalled consumer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 32'h0000_1000 + 32'(4 * i));
            step();
            if (i == 5) chk("s2_not_full_6", 64'(full), 64'd0);
            if (i == 6) chk("s2_full_7", 64'(full), 64'd1);
        end
        drive(1'b0, 1'b0, 32'd0);
        chk("s2_drop", 64'(drop_cnt), 64'd3);
        tr_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("s2_drain_seq", 64'(tr_seq), 64'(i));
            step();
        end
        chk("s2_empty", 64'(tr_valid), 64'd0);

        // Scenario 3/4: halt into the reserved slot, then commits ignored while draining.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 32'h0000_2000 + 32'(4 * i));
            step();
        end
        drive(1'b1, 1'b1, 32'h8000_0100);
        step();
        chk("s3_drop", 64'(drop_cnt), 64'd0);
        chk("s3_full", 64'(full), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, (i == 2) ? 1'b1 : 1'b0, 32'h0000_3000 + 32'(4 * i));
            step();
        end
        drive(1'b0, 1'b0, 32'd0);
        chk("s4_drop", 64'(drop_cnt), 64'd0);
        chk("s4_head_seq", 64'(tr_seq), 64'd0);
        tr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("s3_halt_flag", 64'(tr_halt), 64'd1);
                chk("s3_halt_pc", 64'(tr_pc), 64'h8000_0100);
                chk("s3_halt_seq", 64'(tr_seq), 64'd7);
            end else begin
                chk("s3_pre_halt", 64'(tr_halt), 64'd0);
            end
            step();
        end
        chk("s3_halted", 64'(halted), 64'd1);
        chk("s3_done_valid", 64'(tr_valid), 64'd0);
        drive(1'b1, 1'b0, 32'h0000_4000);
        step();
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("s3_done_stay", 64'(tr_valid), 64'd0);

        // Scenario 5: steady push+pop at count 3 across the pointer wrap.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0000_5000 + 32'(4 * i));
            step();
        end
        tr_ready = 1'b1;
        for (int i = 3; i < 13; i++) begin
            drive(1'b1, 1'b0, 32'h0000_5000 + 32'(4 * i));
            step();
        end
        drive(1'b0, 1'b0, 32'd0);
        chk("s5_head_seq", 64'(tr_seq), 64'd10);
        chk("s5_not_full", 64'(full), 64'd0);
        repeat (3) step();
        chk("s5_empty", 64'(tr_valid), 64'd0);

        // Scenario 6: asynchronous reset in the middle of draining.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0000_6000 + 32'(4 * i));
            step();
        end
        drive(1'b1, 1'b1, 32'h0000_6100);
        step();
        drive(1'b0, 1'b0, 32'd0);
        step();
        chk("s6_pre_valid", 64'(tr_valid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("s6_rst_valid", 64'(tr_valid), 64'd0);
        chk("s6_rst_halt", 64'(tr_halt), 64'd0);
        chk("s6_rst_halted", 64'(halted), 64'd0);
        step();
        resetn = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_7000);
        step();
        drive(1'b0, 1'b0, 32'd0);
        chk("s6_valid", 64'(tr_valid), 64'd1);
        chk("s6_seq", 64'(tr_seq), 64'd0);
        chk("s6_pc", 64'(tr_pc), 64'h0000_7000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
